// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider (signed DIV / unsigned DIVU), one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes right after accept.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div,
  input  logic             divu,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotOut_q, quotOut_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic             dz_q, dz_d;

  logic             isSigned;
  logic             divNeg;
  logic             dsrNeg;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic             lastStep;

  // Operand conditioning at accept: DIV wins over DIVU and divides magnitudes.
  assign isSigned = div;
  assign divNeg   = isSigned & dividend[WIDTH-1];
  assign dsrNeg   = isSigned & divisor[WIDTH-1];
  assign opA      = divNeg ? -dividend : dividend;
  assign opB      = dsrNeg ? -divisor : divisor;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep on no borrow.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {2'b00, dsr_q};
  assign borrow   = trial[WIDTH+1];
  assign stepRem  = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
  assign stepQuo  = {quo_q[WIDTH-2:0], ~borrow};
  assign lastStep = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      raw_q     <= '0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      zero_q    <= 1'b0;
      quotOut_q <= '0;
      remOut_q  <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      raw_q     <= raw_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      zero_q    <= zero_d;
      quotOut_q <= quotOut_d;
      remOut_q  <= remOut_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    raw_d     = raw_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    zero_d    = zero_q;
    quotOut_d = quotOut_q;
    remOut_d  = remOut_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (div | divu) begin
          state_d = RUN;
          count_d = '0;
          rem_d   = '0;
          quo_d   = opA;
          dsr_d   = opB;
          raw_d   = dividend;
          negQ_d  = divNeg ^ dsrNeg;
          negR_d  = divNeg;
          zero_d  = (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            state_d   = DONE;
            quotOut_d = '1;
            remOut_d  = dividend;
            dz_d      = 1'b1;
          end
`endif
        end
      end

      RUN: begin
        rem_d   = stepRem;
        quo_d   = stepQuo;
        count_d = count_q + 1'b1;
        if (lastStep) begin
          state_d = DONE;
          // A zero divisor reports the raw dividend, bypassing the sign fix-up.
          if (zero_q) begin
            quotOut_d = '1;
            remOut_d  = raw_q;
            dz_d      = 1'b1;
          end else begin
            quotOut_d = negQ_q ? -stepQuo : stepQuo;
            remOut_d  = negR_q ? -stepRem[WIDTH-1:0] : stepRem[WIDTH-1:0];
            dz_d      = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign q    = quotOut_q;
  assign r    = remOut_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized DIV/DIVU traffic
// compared against an arithmetic reference model.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        div;
   logic        divu;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;
   logic        dz;

   int vectorCount = 0;
   int missCount = 0;
   int doneCount = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .div(div),
      .divu(divu),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .q(q),
      .r(r),
      .dz(dz)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tally every done pulse so an aborted operation can be shown to produce none
   always @(posedge clk) begin
      if (done) doneCount <= doneCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Architectural result of a divide, straight from the arithmetic definition
   function automatic void refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] qo, output logic [31:0] ro, output logic dzo);
      dzo = (b == 32'd0);
      if (b == 32'd0) begin
         qo = 32'hFFFFFFFF;
         ro = a;
      end else if (sgn) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            qo = 32'h80000000;
            ro = 32'd0;
         end else begin
            qo = 32'($signed(a) / $signed(b));
            ro = 32'($signed(a) % $signed(b));
         end
      end else begin
         qo = a / b;
         ro = a % b;
      end
   endfunction

   // Issue one request, optionally poke the strobes while busy, then check result, latency and hold.
   // Latency is counted in clock edges from the accept edge (inclusive) to the edge raising done:
   // 33 edges for the iterative path, i.e. 34 cycles counting the accept and done cycles.
   task automatic applyStimulus(input logic sDiv, input logic sDivu, input logic [31:0] a,
                                input logic [31:0] b, input int intrudeAt);
      logic [31:0] expQ;
      logic [31:0] expR;
      logic        expDz;
      int          lat;
      int          expLat;
      refModel(sDiv, a, b, expQ, expR, expDz);
      expLat = 33;
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) expLat = 1;
`endif
      @(negedge clk);
      div      = sDiv;
      divu     = sDivu;
      dividend = a;
      divisor  = b;
      lat      = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         div      = 1'b0;
         divu     = 1'b0;
         dividend = $urandom;
         divisor  = $urandom;
         if (lat == 1) checkOutput("busyAfterAccept", 32'(busy), 32'd1);
         if (intrudeAt != 0 && lat == intrudeAt) begin
            div      = 1'b1;
            divu     = 1'b1;
            dividend = 32'd1;
            divisor  = 32'd1;
         end
         if (done) break;
      end
      div  = 1'b0;
      divu = 1'b0;
      checkOutput("latency", 32'(lat), 32'(expLat));
      checkOutput("quotient", q, expQ);
      checkOutput("remainder", r, expR);
      checkOutput("divZero", 32'(dz), 32'(expDz));
      @(posedge clk);
      #1;
      checkOutput("donePulse", 32'(done), 32'd0);
      checkOutput("busyAfterDone", 32'(busy), 32'd0);
      checkOutput("quotientHold", q, expQ);
      checkOutput("remainderHold", r, expR);
   endtask

   // Directed corners, request collision, mid-run reset, then randomized traffic
   initial begin
      int doneBefore;
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      rst      = 1'b0;
      div      = 1'b0;
      divu     = 1'b0;
      dividend = 32'd0;
      divisor  = 32'd0;
      #2 rst = 1'b1;
      #1;
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetQ", q, 32'd0);
      checkOutput("resetR", r, 32'd0);
      checkOutput("resetDz", 32'(dz), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      applyStimulus(1'b0, 1'b1, 32'd100, 32'd7, 0);
      applyStimulus(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 0);
      applyStimulus(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0);
      applyStimulus(1'b0, 1'b1, 32'h00001234, 32'd0, 0);
      applyStimulus(1'b1, 1'b0, 32'hFFFFFF00, 32'd0, 0);
      applyStimulus(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 0);
      applyStimulus(1'b0, 1'b1, 32'd100, 32'd7, 5);

      // Abort a divide partway through RUN with an asynchronous reset
      doneBefore = doneCount;
      @(negedge clk);
      divu     = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(posedge clk);
      #1;
      divu = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortDone", 32'(done), 32'd0);
      checkOutput("abortQ", q, 32'd0);
      checkOutput("abortR", r, 32'd0);
      checkOutput("abortDz", 32'(dz), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'd100, 32'd7, 0);
      checkOutput("abortNoDone", 32'(doneCount - doneBefore), 32'd1);

      for (int i = 0; i < 40; i++) begin
         mode = 2'($urandom_range(0, 2));
         a = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h80000000;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = -32'($urandom_range(1, 15));
            3:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         applyStimulus(mode != 2'd0, mode != 2'd1, a, b, (i % 4 == 0) ? 7 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port div  input  1  DIV decode strobe (signed divide request).
REQ-005 SHALL have port divu  input  1  DIVU decode strobe (unsigned divide request).
REQ-006 SHALL have port dividend  input  32  rs operand, sampled at accept.
REQ-007 SHALL have port divisor  input  32  rt operand, sampled at accept.
REQ-008 SHALL have port busy  output  1  high while a divide is in progress or completing.
REQ-009 SHALL have port done  output  1  one-cycle pulse; q/r valid from this cycle onward.
REQ-010 SHALL have port q  output  32  quotient, destined for LO.
REQ-011 SHALL have port r  output  32  remainder, destined for HI.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag of the last completed operation.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; busy = (state != IDLE).
REQ-014 SHALL accept a request when state is IDLE and (div | divu) is high: latch operands and mode, clear iteration counter, go to RUN.
REQ-015 SHALL give div priority when div and divu are both high (signed operation).
REQ-016 SHALL ignore div/divu while busy; no queuing, no effect on the running operation.
REQ-017 SHALL, for signed mode, divide magnitudes (two's-complement absolute values) and, for unsigned mode, the raw operands.
REQ-018 SHALL perform one restoring radix-2 step per RUN cycle: 33-bit trial subtract of the divisor from the shifted partial remainder; quotient bit = no borrow.
REQ-019 SHALL execute exactly 32 RUN cycles (counter 0..31), then go to DONE.
REQ-020 SHALL register q/r on the RUN->DONE edge; signed fix-up: q negated if operand signs differ, r negated if dividend negative.
REQ-021 SHALL produce q=0x80000000, r=0 for signed 0x80000000 / 0xFFFFFFFF (no trap, no flag).
REQ-022 SHALL assert done for the single DONE cycle, then return to IDLE; a new request is accepted in the next cycle at the earliest.
REQ-023 SHALL hold q, r, dz stable from DONE until the next result is registered.
REQ-024 SHALL yield latency 34 cycles from accept edge to done high (1 accept + 32 RUN + done cycle), for non-zero divisors.
REQ-025 SHALL, for divisor 0 in either mode, yield q=0xFFFFFFFF and r=dividend (raw, unfixed), dz=1; otherwise dz=0.

Reset
REQ-026 SHALL, on rst high at any time including mid-RUN, immediately force state IDLE, counter 0, busy 0, done 0, q 0, r 0, dz 0; the aborted operation produces no done.
REQ-027 SHALL accept a request in the first clock edge after rst deasserts.

Configuration
REQ-028 SHALL support macro DIV_ZERO_FAST_EN.
REQ-029 SHALL, with DIV_ZERO_FAST_EN defined, detect divisor 0 at accept and go directly to DONE (done on the cycle after accept), results per REQ-025.
REQ-030 SHALL, without DIV_ZERO_FAST_EN, run the full 32 iterations for divisor 0 with identical q/r/dz values and latency per REQ-024.

Verification
REQ-031 SHALL cover: divu, 100 / 7 -> done after 34 cycles, q=14, r=2, dz=0.
REQ-032 SHALL cover: div, 0xFFFFFFF9 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
REQ-033 SHALL cover: div, 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, dz=0.
REQ-034 SHALL cover: divu 0x1234 / 0 -> q=0xFFFFFFFF, r=0x1234, dz=1; done 1 cycle after accept with DIV_ZERO_FAST_EN, 34 without.
REQ-035 SHALL cover: divu pulse during RUN of 100/7 -> ignored, result still 14/2; rst at RUN cycle 10 -> busy 0 next cycle, no done, q=r=0.
